// File: rtl/ama_pkg.sv
// Shared definitions for the pipelined approximate adder.
//   - mode encodings carried with every transaction
//   - segment-width helper used to slice operands per stage
//   - per-stage control payload; the matching sum/operand vectors travel
//     alongside it in WIDTH-wide registers owned by each segment
package ama_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Control part of a stage payload: occupancy, mode and the segment carry.
  typedef struct packed {
    logic valid;
    logic mode;
    logic carry;
  } stage_ctl_t;

  // Width of one carry segment.
  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/ama_pipe_seg.sv
// One registered carry segment of the pipelined approximate adder.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   adv                load enable: this stage takes the upstream payload
//   ctl_in / ctl_out   valid, mode and carry entering / leaving the segment
//   sum_in / sum_out   partial sum; bits below this segment already final
//   a_in,b_in/a_out,b_out operands, passed on for the segments above
// Segment SEG owns bits [(SEG+1)*W/S-1 : SEG*W/S]. In approx mode any bit
// with absolute index below APPROX_BITS is produced as a|b and takes no
// part in the carry chain; the LOA carry a[A-1]&b[A-1] re-enters the exact
// adder at bit APPROX_BITS, whichever segment that bit lives in.
module ama_pipe_seg
  import ama_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int STAGES      = 2,
  parameter int SEG         = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  stage_ctl_t       ctl_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output stage_ctl_t       ctl_out,
  output logic [WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  localparam int SW   = seg_width(WIDTH, STAGES);
  localparam int LO   = SEG * SW;
  localparam int HI   = LO + SW - 1;
  localparam int AIDX = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
  // LOA carry lands strictly inside this segment
  localparam bit INJ_HERE = (APPROX_BITS > LO) && (APPROX_BITS <= HI);
  // LOA carry leaves through this segment's carry-out
  localparam bit BND_OUT  = (APPROX_BITS == HI + 1);
  // segment starts inside the approximate region: incoming carry is dead
  localparam bit CIN_KILL = (APPROX_BITS > LO);
  localparam int INJ_POS  = INJ_HERE ? APPROX_BITS - LO : 0;

  logic          approx_s;
  logic [SW-1:0] seg_a_s;
  logic [SW-1:0] seg_b_s;
  logic [SW-1:0] mask_s;
  logic [SW-1:0] ea_s;
  logic [SW-1:0] eb_s;
  logic [SW:0]   inj_s;
  logic          cin_s;
  logic          loa_c_s;
  logic [SW:0]   add_s;
  logic [SW-1:0] psum_s;
  logic          cout_s;
  logic [WIDTH-1:0] nxt_sum_s;

  stage_ctl_t       ctl_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  // Segment adder: exact add on unmasked bits, OR on masked bits.
  always_comb begin
    approx_s = (ctl_in.mode == MODE_APPROX);
    seg_a_s  = a_in[HI:LO];
    seg_b_s  = b_in[HI:LO];
    mask_s   = {SW{1'b0}};
    for (int j = 0; j < SW; j++) begin
      mask_s[j] = approx_s && ((LO + j) < APPROX_BITS);
    end
    loa_c_s = a_in[AIDX] & b_in[AIDX];
    inj_s   = {(SW+1){1'b0}};
    if (approx_s && INJ_HERE) begin
      inj_s[INJ_POS] = loa_c_s;
    end else begin
      inj_s = {(SW+1){1'b0}};
    end
    if (approx_s && CIN_KILL) begin
      cin_s = 1'b0;
    end else begin
      cin_s = ctl_in.carry;
    end
    ea_s   = seg_a_s & ~mask_s;
    eb_s   = seg_b_s & ~mask_s;
    // masked bits are zero in ea/eb and cin is dead there, so no carry
    // can be generated below the injection point
    add_s  = {1'b0, ea_s} + {1'b0, eb_s} + inj_s + {{SW{1'b0}}, cin_s};
    psum_s = (add_s[SW-1:0] & ~mask_s) | ((seg_a_s | seg_b_s) & mask_s);
    cout_s = add_s[SW] | (approx_s && BND_OUT && (a_in[HI] & b_in[HI]));
    nxt_sum_s         = sum_in;
    nxt_sum_s[HI:LO]  = psum_s;
  end

  // Stage register: cleared on reset, loaded when the stage advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_r <= '{valid: 1'b0, mode: 1'b0, carry: 1'b0};
      sum_r <= {WIDTH{1'b0}};
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
    end else if (adv) begin
      ctl_r.valid <= ctl_in.valid;
      ctl_r.mode  <= ctl_in.mode;
      ctl_r.carry <= cout_s;
      sum_r       <= nxt_sum_s;
      a_r         <= a_in;
      b_r         <= b_in;
    end
  end

  assign ctl_out = ctl_r;
  assign sum_out = sum_r;
  assign a_out   = a_r;
  assign b_out   = b_r;

endmodule

// File: rtl/ama_pipe_adder.sv
// Pipelined exact / lower-part-OR approximate adder.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready combinational from out_ready)
//   a, b, cin            operands and carry-in (cin ignored in approx mode)
//   approx_en            1 = approximate, 0 = exact; travels with the data
//   out_valid, out_ready output handshake
//   sum, cout            registered result from the last segment
// Latency is STAGES cycles; each stage accepts when empty or when the stage
// after it advances, so bubbles collapse while the tail is stalled.
module ama_pipe_adder
  import ama_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  stage_ctl_t       ctl_s [0:STAGES];
  logic [WIDTH-1:0] sum_s [0:STAGES];
  logic [WIDTH-1:0] a_s   [0:STAGES];
  logic [WIDTH-1:0] b_s   [0:STAGES];
  logic [STAGES-1:0] vld_s;
  logic [STAGES:0]   adv_s;
  logic              unused_s;

  assign ctl_s[0] = '{valid: in_valid, mode: approx_en, carry: cin};
  assign sum_s[0] = {WIDTH{1'b0}};
  assign a_s[0]   = a;
  assign b_s[0]   = b;

  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    ama_pipe_seg #(
      .WIDTH       (WIDTH),
      .APPROX_BITS (APPROX_BITS),
      .STAGES      (STAGES),
      .SEG         (g)
    ) u_seg (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv_s[g]),
      .ctl_in  (ctl_s[g]),
      .sum_in  (sum_s[g]),
      .a_in    (a_s[g]),
      .b_in    (b_s[g]),
      .ctl_out (ctl_s[g+1]),
      .sum_out (sum_s[g+1]),
      .a_out   (a_s[g+1]),
      .b_out   (b_s[g+1])
    );
    assign vld_s[g] = ctl_s[g+1].valid;
  end

  // Advance chain, evaluated from the output back towards the input.
  always_comb begin
    adv_s         = {(STAGES+1){1'b0}};
    adv_s[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_s[k] = !vld_s[k] || adv_s[k+1];
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = ctl_s[STAGES].valid;
  assign sum       = sum_s[STAGES];
  assign cout      = ctl_s[STAGES].carry;

  // The last stage's copied operands and mode have no consumer.
  assign unused_s = ^{a_s[STAGES], b_s[STAGES], ctl_s[STAGES].mode};

endmodule

// File: tb/tb_ama_pipe_adder.sv
// Directed bench for ama_pipe_adder (WIDTH=16, APPROX_BITS=4, STAGES=2).
module tb_ama_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  int n_vec = 0;
  int n_err = 0;

  ama_pipe_adder #(.WIDTH(16), .APPROX_BITS(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // back-to-back table: even entries exact, odd entries approx
  logic [15:0] bb_a [0:7] = '{16'h1234, 16'h1234, 16'h8000, 16'h8000,
                              16'h00FF, 16'h00FF, 16'h0007, 16'h0007};
  logic [15:0] bb_b [0:7] = '{16'h4321, 16'h4321, 16'h8000, 16'h8000,
                              16'h00FF, 16'h00FF, 16'h0009, 16'h0009};
  logic        bb_c [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [16:0] bb_e [0:7] = '{17'h05555, 17'h05555, 17'h10001, 17'h10000,
                              17'h001FF, 17'h001FF, 17'h00010, 17'h0000F};

  // backpressure table, exact mode, cin=0
  logic [15:0] bp_a [0:3] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
  logic [15:0] bp_b [0:3] = '{16'h0001, 16'h0020, 16'h0300, 16'hF000};
  logic [16:0] bp_e [0:3] = '{17'h00002, 17'h00030, 17'h00400, 17'h10000};

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction through an idle pipe with out_ready=1.
  task automatic run_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic m, input logic [16:0] exp);
    a = av; b = bv; cin = c; approx_en = m; in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 17'(in_ready), 17'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 17'(out_valid), 17'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 17'(out_valid), 17'd1);
    chk({tag, "_res"}, {cout, sum}, exp);
    @(posedge clk); #1;
    chk({tag, "_drain"}, 17'(out_valid), 17'd0);
  endtask

  initial begin
    int  in_idx;
    int  out_idx;
    logic acc;
    logic cons;

    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    cin = 1'b0; approx_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 17'(out_valid), 17'd0);
    chk("rst_res", {cout, sum}, 17'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", 17'(in_ready), 17'd1);

    // isolated directed vectors
    run_one("ex_carry",   16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100);
    run_one("ex_ovf",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
    run_one("ap_ovf",     16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h0FFFF);
    run_one("ap_loa",     16'h0008, 16'h0008, 1'b0, 1'b1, 17'h00018);
    run_one("ex_loa",     16'h0008, 16'h0008, 1'b0, 1'b0, 17'h00010);
    run_one("ap_cin_ign", 16'h000F, 16'h0001, 1'b1, 1'b1, 17'h0000F);
    run_one("ap_seg_cy",  16'h00F0, 16'h0010, 1'b0, 1'b1, 17'h00100);

    // back-to-back alternating modes
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        a = bb_a[i]; b = bb_b[i]; cin = bb_c[i];
        approx_en = (i % 2 == 1) ? 1'b1 : 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 8) chk($sformatf("b2b_rdy%0d", i), 17'(in_ready), 17'd1);
      @(posedge clk); #1;
      if (i >= 1) begin
        chk($sformatf("b2b_vld%0d", i - 1), 17'(out_valid), 17'd1);
        chk($sformatf("b2b_res%0d", i - 1), {cout, sum}, bb_e[i-1]);
      end else begin
        chk("b2b_lat", 17'(out_valid), 17'd0);
      end
    end
    @(posedge clk); #1;
    chk("b2b_empty", 17'(out_valid), 17'd0);

    // backpressure: 5 stalled cycles, then drain
    in_idx = 0; out_idx = 0;
    out_ready = 1'b0; approx_en = 1'b0; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = bp_a[in_idx]; b = bp_b[in_idx]; in_valid = 1'b1;
      #1;
      chk($sformatf("bp_rdy%0d", i), 17'(in_ready), (i < 2) ? 17'd1 : 17'd0);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) in_idx++;
      if (i >= 1) begin
        chk($sformatf("bp_vld%0d", i), 17'(out_valid), 17'd1);
        chk($sformatf("bp_hold%0d", i), {cout, sum}, bp_e[0]);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_idx < 4; i++) begin
      if (in_idx < 4) begin
        a = bp_a[in_idx]; b = bp_b[in_idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) in_idx++;
      if (cons) out_idx++;
      if (out_valid && out_idx < 4)
        chk($sformatf("bp_drain%0d", out_idx), {cout, sum}, bp_e[out_idx]);
    end
    in_valid = 1'b0;
    chk("bp_count", 17'(out_idx), 17'd4);
    chk("bp_empty", 17'(out_valid), 17'd0);

    // reset with both stages occupied
    out_ready = 1'b0; approx_en = 1'b0; cin = 1'b0;
    a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h2222; b = 16'h2222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rm_pre_vld", 17'(out_valid), 17'd1);
    chk("rm_pre_res", {cout, sum}, 17'h02222);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rm_vld", 17'(out_valid), 17'd0);
    chk("rm_res", {cout, sum}, 17'd0);
    chk("rm_rdy", 17'(in_ready), 17'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rm_stale%0d", i), 17'(out_valid), 17'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
